// File: rtl/em_rr_scheduler_pkg.sv
// Shared constants for the round-robin exponent/multiply engine scheduler:
// FSM state encoding, engine select encoding and engine data widths.
package em_rr_scheduler_pkg;

    // Engine data widths
    localparam int EM_P_W  = 30;
    localparam int EM_OP_W = 4;

    // Engine op select encoding
    localparam logic SEL_EXP = 1'b1;
    localparam logic SEL_MUL = 1'b0;

    // Scheduler FSM states
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;
    localparam logic [2:0] S_GAP     = 3'd5;

endpackage

// File: rtl/em_rr_scheduler_if.sv
// Control/data bundle between the scheduler (master) and the shared
// exponent/multiply engine (slave).
interface em_rr_scheduler_if;
    import em_rr_scheduler_pkg::*;

    logic                load;
    logic                start;
    logic                select;
    logic [EM_OP_W-1:0]  a;
    logic [EM_OP_W-1:0]  b;
    logic                done;
    logic [EM_P_W-1:0]   p;

    modport master (output load, start, select, a, b, input done, p);
    modport slave  (input load, start, select, a, b, output done, p);

endinterface

// File: rtl/em_rr_arbiter.sv
// Combinational round-robin next-grant logic: scans requests upward from
// i_ptr+1 (modulo N_REQ) and returns a one-hot grant plus its index.
module em_rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]  o_idx,
    output logic             o_any
);

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;

    // Rotate requests so bit 0 is the requester right after the pointer
    assign w_dbl = {i_req, i_req};
    assign w_rot = N_REQ'(w_dbl >> (int'(i_ptr) + 1));

    // Lowest set bit of the rotated vector wins; scan downward so it is written last
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise a path that skips the assignment infers a latch.
        o_any = 1'b0;
        o_idx = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                o_any = 1'b1;
                o_idx = ID_W'((int'(i_ptr) + 1 + j) % N_REQ);
            end
        end
    end

    // Expand the winning index to a one-hot grant
    always_comb begin
        o_gnt = '0;
        for (int k = 0; k < N_REQ; k++) begin
            o_gnt[k] = o_any && (o_idx == ID_W'(k));
        end
    end

endmodule

// File: rtl/em_rr_scheduler.sv
// Round-robin scheduler sharing one exponent/multiply engine among N_REQ
// requesters. Runs the engine load -> start -> wait-done -> release sequence
// for the winning requester and returns the tagged result with its latency.
module em_rr_scheduler
    import em_rr_scheduler_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = 2,
    parameter int LAT_W = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [4*N_REQ-1:0]     i_A,
    input  logic [4*N_REQ-1:0]     i_B,
    input  logic [N_REQ-1:0]       i_sel,
    output logic [N_REQ-1:0]       o_gnt,
    output logic                   o_rsp_valid,
    output logic [ID_W-1:0]        o_rsp_id,
    output logic [EM_P_W-1:0]      o_rsp_data,
    output logic [LAT_W-1:0]       o_rsp_lat,
    output logic                   o_busy,
    em_rr_scheduler_if.master      em_bus
);

    logic [2:0]          r_state;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_id;
    logic [EM_OP_W-1:0]  r_a;
    logic [EM_OP_W-1:0]  r_b;
    logic                r_sel;
    logic [LAT_W-1:0]    r_lat;
    logic                r_rsp_valid;
    logic [ID_W-1:0]     r_rsp_id;
    logic [EM_P_W-1:0]   r_rsp_data;
    logic [LAT_W-1:0]    r_rsp_lat;

    logic [N_REQ-1:0]    w_arb_gnt;
    logic [ID_W-1:0]     w_arb_idx;
    logic                w_arb_any;
    logic                w_idle;
    logic                w_take;
    logic                w_done_hit;
    logic [EM_OP_W-1:0]  w_a;
    logic [EM_OP_W-1:0]  w_b;
    logic                w_sel;
    logic [LAT_W-1:0]    w_lat_inc;

    em_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arbiter (
        .i_req (i_req),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

    assign w_idle     = (r_state == S_IDLE);
    assign w_take     = w_idle && w_arb_any;
    assign w_done_hit = (r_state == S_WAIT) && em_bus.done;
    assign w_lat_inc  = (&r_lat) ? r_lat : r_lat + LAT_W'(1);

    // Pick the winner's operands; other requesters' operands are never sampled
    always_comb begin
        w_a   = '0;
        w_b   = '0;
        w_sel = SEL_MUL;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_arb_gnt[k]) begin
                w_a   = i_A[4*k +: 4];
                w_b   = i_B[4*k +: 4];
                w_sel = i_sel[k];
            end
        end
    end

    // Job FSM: arbitrate in IDLE, latch the job, then step the engine protocol
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values and blocks can't race each other.
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= ID_W'(N_REQ - 1);
            r_id    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sel   <= SEL_MUL;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_ptr   <= w_arb_idx;
                        r_id    <= w_arb_idx;
                        r_a     <= w_a;
                        r_b     <= w_b;
                        r_sel   <= w_sel;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD:    r_state <= S_START;
                S_START:   r_state <= S_WAIT;
                S_WAIT:    if (em_bus.done) r_state <= S_RELEASE;
                S_RELEASE: r_state <= S_GAP;
                S_GAP:     r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    // Saturating count of WAIT cycles, cleared when the engine is started
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lat <= '0;
        end else if (r_state == S_START) begin
            r_lat <= '0;
        end else if (r_state == S_WAIT) begin
            r_lat <= w_lat_inc;
        end
    end

    // Capture the engine result on the first done seen in WAIT
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_lat   <= '0;
        end else begin
            r_rsp_valid <= w_done_hit;
            if (w_done_hit) begin
                r_rsp_id   <= r_id;
                r_rsp_data <= em_bus.p;
                r_rsp_lat  <= w_lat_inc;
            end
        end
    end

    assign o_gnt       = w_idle ? w_arb_gnt : '0;
    assign o_busy      = !w_idle;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_lat   = r_rsp_lat;

    // Start is high in START (kick off) and RELEASE (return engine to idle) only;
    // select is held while the engine owns the job since it samples it in FINISH
    assign em_bus.load   = (r_state == S_LOAD);
    assign em_bus.start  = (r_state == S_START) || (r_state == S_RELEASE);
    assign em_bus.select = !w_idle && r_sel;
    assign em_bus.a      = r_a;
    assign em_bus.b      = r_b;

endmodule

// File: tb/tb_em_rr_scheduler.sv
// Directed bench for em_rr_scheduler with a behavioural engine model.
// A second instance with LAT_W=2 sees identical stimulus and engine replies.
module tb_em_rr_scheduler;
    import em_rr_scheduler_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req   = '0;
    logic [7:0]  a_bus = '0;
    logic [7:0]  b_bus = '0;
    logic [1:0]  sel   = '0;

    logic [1:0]  gnt0, gnt1;
    logic        rsp_valid0, rsp_valid1;
    logic [1:0]  rsp_id0, rsp_id1;
    logic [29:0] rsp_data0, rsp_data1;
    logic [7:0]  lat0;
    logic [1:0]  lat1;
    logic        busy0, busy1;

    int n_vec = 0;
    int n_err = 0;

    em_rr_scheduler_if em0 ();
    em_rr_scheduler_if em1 ();

    assign em1.done = em0.done;
    assign em1.p    = em0.p;

    em_rr_scheduler #(.N_REQ(2), .ID_W(2), .LAT_W(8)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_A(a_bus), .i_B(b_bus), .i_sel(sel),
        .o_gnt(gnt0), .o_rsp_valid(rsp_valid0), .o_rsp_id(rsp_id0), .o_rsp_data(rsp_data0),
        .o_rsp_lat(lat0), .o_busy(busy0), .em_bus(em0.master)
    );

    em_rr_scheduler #(.N_REQ(2), .ID_W(2), .LAT_W(2)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_A(a_bus), .i_B(b_bus), .i_sel(sel),
        .o_gnt(gnt1), .o_rsp_valid(rsp_valid1), .o_rsp_id(rsp_id1), .o_rsp_data(rsp_data1),
        .o_rsp_lat(lat1), .o_busy(busy1), .em_bus(em1.master)
    );

    always #5 clk = ~clk;

    // Engine model: load latches operands, start arms it, computation runs
    // while start is low (B+1 cycles for exp, 1 for mul), done holds until
    // the release start pulse.
    localparam int E_IDLE = 0, E_LOADED = 1, E_RUN = 2, E_FIN = 3;
    int         e_state;
    int         e_cnt;
    logic [3:0] e_a, e_b;

    function automatic logic [29:0] eng_result(input logic [3:0] a, input logic [3:0] b, input logic s);
        logic [63:0] r;
        r = 64'd1;
        if (s == SEL_EXP) begin
            for (int i = 0; i < int'(b); i++) r = r * 64'(a);
        end else begin
            r = 64'(a) * 64'(b);
        end
        return r[29:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_state  <= E_IDLE;
            e_cnt    <= 0;
            e_a      <= '0;
            e_b      <= '0;
            em0.done <= 1'b0;
            em0.p    <= '0;
        end else begin
            case (e_state)
                E_IDLE: if (em0.load) begin
                    e_a     <= em0.a;
                    e_b     <= em0.b;
                    e_state <= E_LOADED;
                end
                E_LOADED: if (em0.start) begin
                    e_state <= E_RUN;
                    e_cnt   <= (em0.select == SEL_EXP) ? int'(e_b) + 1 : 1;
                end
                E_RUN: if (!em0.start) begin
                    if (e_cnt == 0) begin
                        e_state  <= E_FIN;
                        em0.done <= 1'b1;
                        em0.p    <= eng_result(e_a, e_b, em0.select);
                    end else begin
                        e_cnt <= e_cnt - 1;
                    end
                end
                default: if (em0.start) begin
                    e_state  <= E_IDLE;
                    em0.done <= 1'b0;
                end
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One isolated job from requester k; exp_w is the hand-computed WAIT length
    task automatic run_job(input int k, input logic [3:0] a, input logic [3:0] b, input logic s,
                           input logic [29:0] exp_p, input int exp_w, output int lat_seen);
        int  waits;
        bit  got;
        lat_seen = 0;
        @(negedge clk);
        a_bus[4*k +: 4] = a;
        b_bus[4*k +: 4] = b;
        sel[k]          = s;
        req[k]          = 1'b1;
        #1;
        check("gnt", 32'(gnt0), 32'(1) << k);
        check("busy_idle", 32'(busy0), 32'd0);
        @(negedge clk);
        req[k] = 1'b0;
        check("load_pulse", 32'({em0.load, em0.start}), 32'b10);
        check("em_ab", 32'({em0.a, em0.b}), 32'({a, b}));
        check("em_sel", 32'(em0.select), 32'(s));
        @(negedge clk);
        check("start_pulse", 32'({em0.load, em0.start}), 32'b01);
        waits = 0;
        got   = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (rsp_valid0) begin
                got = 1'b1;
            end else begin
                waits++;
                check("wait_start_low", 32'(em0.start), 32'd0);
            end
        end
        if (!got) begin
            check("rsp_timeout", 32'(rsp_valid0), 32'd1);
        end else begin
            check("wait_len", 32'(waits), 32'(exp_w));
            check("rsp_data", 32'(rsp_data0), 32'(exp_p));
            check("rsp_id", 32'(rsp_id0), 32'(k));
            check("rsp_lat", 32'(lat0), 32'(exp_w));
            check("rsp_lat_sat", 32'(lat1), 32'((exp_w > 3) ? 3 : exp_w));
            check("release_start", 32'({em0.load, em0.start, em0.select}), 32'({2'b01, s}));
            lat_seen = int'(lat0);
            @(negedge clk);
            check("gap", 32'({rsp_valid0, em0.start, busy0}), 32'b001);
            @(negedge clk);
            check("back_idle", 32'({busy0, em0.select}), 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl0"}, 32'({gnt0, rsp_valid0, busy0, em0.load, em0.start, em0.select}), 32'd0);
        check({tag, "_ops0"}, 32'({em0.a, em0.b, rsp_id0, lat0}), 32'd0);
        check({tag, "_data0"}, 32'(rsp_data0), 32'd0);
        check({tag, "_all1"}, 32'({gnt1, rsp_valid1, busy1, em1.load, em1.start, em1.select,
                                   em1.a, em1.b, rsp_id1, lat1}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat_b1, lat_b15, lat_x;
        int n_g, last_c, cur, starts, loads, rsp_seen;
        bit got;

        // Reset state
        @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single exp job: 3^4
        run_job(0, 4'd3, 4'd4, 1'b1, 30'd81, 7, lat_x);
        // Multiply path and large exponent on requester 1
        run_job(1, 4'd15, 4'd15, 1'b0, 30'd225, 3, lat_x);
        run_job(1, 4'd2, 4'd15, 1'b1, 30'd32768, 18, lat_b15);
        // Short exp job for latency ordering
        run_job(0, 4'd5, 4'd1, 1'b1, 30'd5, 4, lat_b1);
        check("lat_order", 32'(lat_b15 > lat_b1), 32'd1);
        // Zero exponent and zero product
        run_job(0, 4'd0, 4'd0, 1'b1, 30'd1, 3, lat_x);
        run_job(1, 4'd0, 4'd0, 1'b0, 30'd0, 3, lat_x);

        // Contention: req0 = 2^1 (WAIT 4), req1 = 3*2 (WAIT 3)
        @(negedge clk);
        a_bus = {4'd3, 4'd2};
        b_bus = {4'd2, 4'd1};
        sel   = 2'b01;
        req   = 2'b11;
        #1;
        n_g = 0; last_c = 0; cur = 0; starts = 0; loads = 0; rsp_seen = 0;
        for (int c = 0; c < 200 && n_g < 4; c++) begin
            if (gnt0 != 2'b00) begin
                check("cont_onehot", 32'($countones(gnt0)), 32'd1);
                check("cont_order", 32'(gnt0[1]), 32'(n_g % 2));
                if (n_g > 0) begin
                    check("cont_spacing", 32'(c - last_c), 32'((cur == 0) ? 9 : 8));
                    check("cont_starts", 32'(starts), 32'd2);
                    check("cont_loads", 32'(loads), 32'd1);
                    check("cont_rsps", 32'(rsp_seen), 32'd1);
                end
                cur = gnt0[1] ? 1 : 0;
                last_c = c; n_g++; starts = 0; loads = 0; rsp_seen = 0;
            end
            if (em0.start) starts++;
            if (em0.load) loads++;
            if (rsp_valid0) begin
                rsp_seen++;
                check("cont_id", 32'(rsp_id0), 32'(cur));
                check("cont_data", 32'(rsp_data0), (cur == 0) ? 32'd2 : 32'd6);
            end
            if (n_g < 4) begin
                @(negedge clk);
                #1;
            end
        end
        check("cont_grants", 32'(n_g), 32'd4);
        @(negedge clk);
        req = 2'b00;
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (rsp_valid0) begin
                got = 1'b1;
                check("cont_last_id", 32'(rsp_id0), 32'd1);
                check("cont_last_data", 32'(rsp_data0), 32'd6);
            end
        end
        if (!got) check("cont_last_timeout", 32'(rsp_valid0), 32'd1);
        repeat (3) @(negedge clk);
        check("cont_drained", 32'(busy0), 32'd0);

        // Reset during WAIT of a B=15 exp job
        @(negedge clk);
        a_bus[7:4] = 4'd2;
        b_bus[7:4] = 4'd15;
        sel[1]     = 1'b1;
        req        = 2'b10;
        @(negedge clk);
        req = 2'b00;
        repeat (5) @(negedge clk);
        check("pre_reset_busy", 32'(busy0), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rsp_seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rsp_valid0 || rsp_valid1) rsp_seen++;
        end
        check("no_rsp_after_reset", 32'(rsp_seen), 32'd0);
        run_job(1, 4'd2, 4'd3, 1'b1, 30'd8, 6, lat_x);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/em_rr_scheduler.md
Name: em_rr_scheduler

Overview:
- Round-robin scheduler sharing one exponent/multiply engine (4-bit A, B; 30-bit result; load/start/select/done handshake) among N_REQ requesters, e.g. the AXI4-Lite register bank and a local test source.
- Arbitrates requests, latches operands, sequences the engine's load -> start -> wait-done -> release protocol, and returns the tagged result to the winning requester.
- Sits between the requesters and the engine; the engine has no other master.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- ID_W, 2, width of the requester index; must satisfy 2**ID_W >= N_REQ.
- LAT_W, 8, width of the saturating latency counter.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_req  in  N_REQ  per-requester request level; held with its operands until granted.
- i_A  in  4*N_REQ  packed operand A; requester k occupies bits [4k+3:4k].
- i_B  in  4*N_REQ  packed operand B, same packing.
- i_sel  in  N_REQ  per-requester op select: 1 = A^B, 0 = A*B.
- o_gnt  out  N_REQ  one-hot, one-cycle pulse: request accepted, operands latched.
- o_rsp_valid  out  1  one-cycle pulse: result available.
- o_rsp_id  out  ID_W  index of the requester owning o_rsp_data.
- o_rsp_data  out  30  result; A*B zero-extended from 8 bits.
- o_rsp_lat  out  LAT_W  cycles spent in WAIT for this job; saturates at all-ones.
- o_busy  out  1  high in every state except IDLE.
- o_em_load, o_em_start, o_em_select  out  1 each  engine controls.
- o_em_A, o_em_B  out  4 each  engine operands.
- i_em_done  in  1  engine done (registered, high while the engine is in FINISH).
- i_em_P  in  30  engine result, valid whenever i_em_done is high.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, RR pointer = N_REQ-1, so requester 0 has first priority. The engine shares i_rst_n; reset mid-job returns both blocks to idle and drops the job with no response.
- FSM states: IDLE, LOAD, START, WAIT, RELEASE, GAP.
- IDLE:
  - If any i_req is set, grant the first set index scanning upward from pointer+1 modulo N_REQ.
  - In the same cycle: pulse o_gnt[k]; latch A, B and sel of requester k plus id k; pointer <= k; go to LOAD.
  - No request -> stay.
- LOAD: o_em_load = 1 for exactly this cycle, with o_em_A/o_em_B driven from the latched operands; -> START.
- START: o_em_start = 1 for exactly this cycle; clear the latency counter; -> WAIT.
- WAIT:
  - o_em_start = 0; this is mandatory, because the engine computes only while start is low.
  - Latency counter increments each cycle, saturating.
  - On i_em_done = 1: capture i_em_P into o_rsp_data, set o_rsp_id and o_rsp_lat, pulse o_rsp_valid; -> RELEASE.
  - No timeout; the engine always completes.
- RELEASE: o_em_start = 1 for one cycle, which returns the engine to idle; -> GAP.
- GAP:
  - One dead cycle. i_em_done may still read 1 here and is ignored.
  - Requests are not sampled; -> IDLE.
- o_em_select holds the latched sel from LOAD through GAP, since the engine samples select every FINISH cycle. o_em_A/o_em_B hold the latched values throughout.
- Response timing: o_rsp_valid is asserted in the cycle after i_em_done first rises. There is no backpressure; the requester must accept the pulse.
- Back-to-back: the minimum gap between successive o_gnt pulses is job WAIT length + 5 cycles.
- A requester whose i_req stays high after its grant is re-arbitrated normally and gets lowest priority next time.
- i_req changes while not in IDLE are ignored. Operands for non-granted requesters are never sampled.
- Fairness: with all N_REQ requesting continuously, grants rotate 0,1,..,N_REQ-1,0.
- Result width: no arithmetic is done in this block; data passes through unmodified.

Decomposition:
- Shared package: FSM state encoding constants, the engine select encoding (SEL_EXP = 1, SEL_MUL = 0), and the engine result width constant (30).
- One sub-module: em_rr_arbiter, combinational next-grant logic from (i_req, pointer) producing a one-hot grant and the encoded index. Pointer register and FSM stay in the top.

Test Plan:
- Single job: req0, A=3, B=4, sel=1 -> o_gnt=01; one load pulse, then one start pulse; o_rsp_data=81, o_rsp_id=0, then a release start pulse.
- Multiply path: req1, A=15, B=15, sel=0 -> o_rsp_data=225, id=1; then A=2, B=15, sel=1 -> 32768.
- Zero exponent: A=0, B=0, sel=1 -> o_rsp_data=1; A=0, B=0, sel=0 -> 0.
- Contention: req0 and req1 held high for 4 jobs -> grant order 0,1,0,1. Check o_em_start is low for every WAIT cycle and grant-to-grant spacing is at least WAIT length + 5.
- Reset mid-WAIT: assert i_rst_n low during WAIT of a B=15 job -> all outputs 0, no o_rsp_valid; a following req1 job, A=2, B=3, sel=1, returns 8.
- Latency: B=15 exp job -> o_rsp_lat strictly greater than for a B=1 job; with LAT_W=2 both report 3 (saturation).
